// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and RV32I load/store encodings for the data-memory bus bridge.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } bridge_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // An access is refused when its funct3 has no meaning for the direction or
  // its address is not naturally aligned for the access size.
  function automatic logic req_illegal(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad_funct3;
    logic bad_align;
    if (write) begin
      bad_funct3 = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    end else begin
      bad_funct3 = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
    case (funct3[1:0])
      2'b01:   bad_align = addr_lo[0];
      2'b10:   bad_align = (addr_lo != 2'b00);
      default: bad_align = 1'b0;
    endcase
    return bad_funct3 || bad_align;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory bridge: store byte enables and lane
// replication, plus load lane selection with sign or zero extension.
module dmem_lane_align
  import dmem_bus_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata_word,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata_lane,
  output logic [DATA_WIDTH-1:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Stores put the datum on every lane so the enabled lane always carries it.
  always_comb begin
    be         = '1;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = BE_WIDTH'(1) << addr_lo;
        wdata_lane = {BE_WIDTH{wdata[7:0]}};
      end
      2'b01: begin
        be         = BE_WIDTH'(3) << {addr_lo[1], 1'b0};
        wdata_lane = {(DATA_WIDTH/16){wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = rdata_word[{addr_lo, 3'b000} +: 8];
    rd_half = rdata_word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   rdata_ext = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      F3_LH:   rdata_ext = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      F3_LBU:  rdata_ext = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
      F3_LHU:  rdata_ext = {{(DATA_WIDTH-16){1'b0}}, rd_half};
      default: rdata_ext = rdata_word;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Connects the pipeline memory stage to a request/grant data bus, stalling the
// pipeline until each load or store completes.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_funct3_i,
  output logic                  stall_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misaligned_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [DATA_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [BE_WIDTH-1:0]   bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  bridge_state_e state_q, state_d;

  logic                  capture;
  logic [DATA_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [2:0]            cap_funct3;
  logic                  cap_write;

  logic [BE_WIDTH-1:0]   lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] lane_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The bus sees only the captured copy, so upstream may change freely once stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= '0;
      cap_write  <= 1'b0;
    end else if (capture) begin
      cap_addr   <= req_addr_i;
      cap_wdata  <= req_wdata_i;
      cap_funct3 <= req_funct3_i;
      cap_write  <= req_write_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o <= '0;
    end else if (state_q == WAIT_R && bus_rvalid_i) begin
      rdata_o <= lane_rdata;
    end
  end

  // DONE always falls back to IDLE without looking at req_valid_i, because the
  // request still presented there is the one just finished.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    stall_o      = 1'b0;
    rsp_valid_o  = 1'b0;
    misaligned_o = 1'b0;
    bus_req_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_illegal(req_write_i, req_funct3_i, req_addr_i[1:0])) begin
            misaligned_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            capture = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          state_d = cap_write ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_lane_align (
    .addr_lo    (cap_addr[1:0]),
    .funct3     (cap_funct3),
    .wdata      (cap_wdata),
    .rdata_word (bus_rdata_i),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  assign bus_addr_o  = {cap_addr[DATA_WIDTH-1:2], 2'b00};
  assign bus_we_o    = bus_req_o & cap_write;
  assign bus_be_o    = bus_req_o ? lane_be : '0;
  assign bus_wdata_o = lane_wdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge: expected per-cycle outputs come from a
// transaction-level timeline and a byte-array view of each load or store.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [2:0]  req_funct3_i = '0;
  logic        stall_o, rsp_valid_o, misaligned_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  typedef struct packed {
    logic        stall;
    logic        rsp;
    logic        mis;
    logic        breq;
    logic        chk_bus;
    logic        chk_rst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rdata = '0;
  int          stall_run = 0;
  int          last_stall = 0;
  int          mis_seen = 0;
  int          req_seen = 0;
  int          m0, q0;
  logic [3:0]  obs_be = '0;
  logic [31:0] obs_addr = '0;
  logic [31:0] obs_wdata = '0;

  dmem_bus_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_funct3_i (req_funct3_i),
    .stall_o      (stall_o),
    .rsp_valid_o  (rsp_valid_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, act, req);
    end
  endfunction

  // Access size in bytes, or 0 when funct3 has no meaning for the direction.
  function automatic int access_size(input logic wr, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return wr ? 0 : 1;
      3'd5: return wr ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input int a, input int n);
    logic [3:0] be;
    for (int k = 0; k < 4; k++) be[k] = (k >= a) && (k < a + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] w, input int n);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = w[8*(k % n) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int a, input int n,
                                             input logic unsigned_ld);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = word[8*(a+k) +: 8];
    if (!unsigned_ld && n < 4 && v[8*n-1]) begin
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic exp_t quiet_exp();
    exp_t e;
    e = '0;
    e.rdata = model_rdata;
    return e;
  endfunction

  // Compare process: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (stall_o) begin
      stall_run++;
    end else begin
      if (rsp_valid_o) last_stall = stall_run;
      stall_run = 0;
    end
    if (misaligned_o) mis_seen++;
    if (bus_req_o) begin
      req_seen++;
      obs_be    = bus_be_o;
      obs_addr  = bus_addr_o;
      obs_wdata = bus_wdata_o;
    end
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("stall_o", 32'(stall_o), 32'(cur.stall));
      check("rsp_valid_o", 32'(rsp_valid_o), 32'(cur.rsp));
      check("misaligned_o", 32'(misaligned_o), 32'(cur.mis));
      check("bus_req_o", 32'(bus_req_o), 32'(cur.breq));
      check("rdata_o", rdata_o, cur.rdata);
      if (cur.chk_bus || cur.chk_rst) begin
        check("bus_we_o", 32'(bus_we_o), 32'(cur.we));
        check("bus_addr_o", bus_addr_o, cur.addr);
        check("bus_be_o", 32'(bus_be_o), 32'(cur.be));
      end
      if (cur.chk_bus && cur.we) check("bus_wdata_o", bus_wdata_o, cur.wdata);
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid_i  = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'($urandom);
      bus_rdata_i  = $urandom;
      step(quiet_exp());
    end
  endtask

  // One memory-stage request; g = cycles before grant, r = cycles before rvalid.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword,
                         input int g, input int r);
    int   n, a;
    exp_t e;
    n = access_size(wr, f3);
    a = int'(addr[1:0]);
    req_valid_i  = 1'b1;
    req_write_i  = wr;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'($urandom);
    bus_rdata_i  = $urandom;
    e = quiet_exp();
    if (n == 0 || (a % n) != 0) begin
      e.mis = 1'b1;
      step(e);
      req_valid_i = 1'b0;
      return;
    end
    e.stall = 1'b1;
    step(e);
    for (int i = 0; i <= g; i++) begin
      req_addr_i   = $urandom;
      req_wdata_i  = $urandom;
      req_funct3_i = 3'($urandom);
      req_write_i  = 1'($urandom);
      bus_gnt_i    = (i == g);
      bus_rvalid_i = 1'($urandom);
      bus_rdata_i  = $urandom;
      e = quiet_exp();
      e.stall   = 1'b1;
      e.breq    = 1'b1;
      e.chk_bus = 1'b1;
      e.we      = wr;
      e.addr    = {addr[31:2], 2'b00};
      e.be      = model_be(a, n);
      e.wdata   = model_wdata(wdata, n);
      step(e);
    end
    bus_gnt_i = 1'b0;
    if (!wr) begin
      for (int j = 0; j <= r; j++) begin
        bus_rvalid_i = (j == r);
        bus_rdata_i  = (j == r) ? rword : $urandom;
        e = quiet_exp();
        e.stall = 1'b1;
        step(e);
      end
      model_rdata = model_load(rword, a, n, f3[2]);
    end
    req_write_i  = wr;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    bus_rvalid_i = 1'($urandom);
    bus_rdata_i  = $urandom;
    e = quiet_exp();
    e.rsp = 1'b1;
    step(e);
    req_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    @(posedge clk);
    #1;
    e = quiet_exp();
    e.chk_rst = 1'b1;
    step(e);
    step(e);
    rst_n = 1'b1;
    idle_cycles(2);

    run_txn(1'b1, F3_SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("sw_stall_cycles", last_stall, 2);
    check("sw_be", 32'(obs_be), 32'h0000_000F);
    check("sw_addr", obs_addr, 32'h0000_0100);
    check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);

    run_txn(1'b0, F3_LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0);
    check("lb_rdata", rdata_o, 32'hFFFF_FF80);
    check("lb_stall_cycles", last_stall, 3);

    run_txn(1'b0, F3_LHU, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, 0);
    check("lhu_rdata", rdata_o, 32'h0000_BEEF);
    run_txn(1'b0, F3_LH, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 1, 2);
    check("lh_rdata", rdata_o, 32'hFFFF_BEEF);

    run_txn(1'b1, F3_SH, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 4, 0);
    check("sh_be", 32'(obs_be), 32'h0000_000C);
    check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_stall_cycles", last_stall, 6);

    m0 = mis_seen;
    q0 = req_seen;
    run_txn(1'b0, F3_LW, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    idle_cycles(1);
    check("lw_mis_pulses", mis_seen, m0 + 1);
    check("lw_no_bus_req", req_seen, q0);

    // Reset while waiting for read data, then a stale rvalid afterwards.
    req_valid_i  = 1'b1;
    req_write_i  = 1'b0;
    req_funct3_i = F3_LW;
    req_addr_i   = 32'h0000_0200;
    bus_rvalid_i = 1'b0;
    e = quiet_exp();
    e.stall = 1'b1;
    step(e);
    bus_gnt_i = 1'b1;
    e = quiet_exp();
    e.stall   = 1'b1;
    e.breq    = 1'b1;
    e.chk_bus = 1'b1;
    e.addr    = 32'h0000_0200;
    e.be      = 4'hF;
    step(e);
    bus_gnt_i = 1'b0;
    e = quiet_exp();
    e.stall = 1'b1;
    step(e);
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    model_rdata = '0;
    e = quiet_exp();
    e.chk_rst = 1'b1;
    step(e);
    step(e);
    rst_n        = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h1234_5678;
    step(e);
    bus_rvalid_i = 1'b0;
    step(e);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_no_rsp_stall", 32'(stall_o), 32'h0);

    for (int t = 0; t < 200; t++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(2);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data and address width.
REQ-002 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, the byte-enable width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i, input, 1, memory stage holds a load or store.
REQ-006 SHALL have port req_write_i, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_addr_i, input, DATA_WIDTH, byte address (ALU result).
REQ-008 SHALL have port req_wdata_i, input, DATA_WIDTH, store data, right-aligned.
REQ-009 SHALL have port req_funct3_i, input, 3, RV32I load/store size and signedness.
REQ-010 SHALL have port stall_o, input-to-pipeline output, 1, hold the memory stage and everything upstream.
REQ-011 SHALL have port rsp_valid_o, output, 1, the access completes this cycle.
REQ-012 SHALL have port rdata_o, output, DATA_WIDTH, load result after sign or zero extension.
REQ-013 SHALL have port misaligned_o, output, 1, one-cycle pulse when a request is misaligned or illegal.
REQ-014 SHALL have port bus_req_o, output, 1, bus request.
REQ-015 SHALL have port bus_we_o, output, 1, bus write.
REQ-016 SHALL have port bus_addr_o, output, DATA_WIDTH, word-aligned address (bits [1:0] = 0).
REQ-017 SHALL have port bus_wdata_o, output, DATA_WIDTH, lane-replicated store data.
REQ-018 SHALL have port bus_be_o, output, BE_WIDTH, byte enables.
REQ-019 SHALL have port bus_gnt_i, input, 1, the bus accepts the request this cycle.
REQ-020 SHALL have port bus_rvalid_i, input, 1, read data valid.
REQ-021 SHALL have port bus_rdata_i, input, DATA_WIDTH, read data word.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, WAIT_R and DONE.
REQ-023 In IDLE with req_valid_i=1 and the request legal, the FSM SHALL drive stall_o=1 combinationally, capture address, data, funct3 and write, and move to REQ.
REQ-024 A request SHALL be illegal when the halfword address has addr[0]=1, the word address has addr[1:0]!=0, or funct3 is 011, 110 or 111 (110/111 for loads; 011 and above for stores).
REQ-025 For an illegal request, the bridge SHALL pulse misaligned_o=1 for one cycle, hold stall_o=0, issue no bus access and stay in IDLE.
REQ-026 In REQ, bus_req_o SHALL be 1 with captured fields stable until bus_gnt_i=1.
REQ-027 On grant, a store SHALL move to DONE and a load SHALL move to WAIT_R.
REQ-028 In WAIT_R, the bridge SHALL wait for bus_rvalid_i=1, then register the extended data and move to DONE.
REQ-029 bus_rvalid_i SHALL be ignored outside WAIT_R.
REQ-030 In DONE, stall_o SHALL be 0 and rsp_valid_o SHALL be 1, and the FSM SHALL return to IDLE unconditionally. The request still visible in DONE is the completed one and SHALL NOT be reissued.
REQ-031 stall_o SHALL be 1 in REQ and WAIT_R.
REQ-032 Latency with zero-wait bus: a store SHALL stall 2 cycles and a load SHALL stall 3 cycles.
REQ-033 Byte enables SHALL be: SB = 0001<<addr[1:0], SH = 0011<<{addr[1],0}, SW = 1111.
REQ-034 Store data SHALL be byte-replicated for SB, halfword-replicated for SH, unchanged for SW.
REQ-035 Loads SHALL select the byte or halfword lane by addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-036 rdata_o SHALL hold its value until the next load completes.
REQ-037 Unbounded gnt or rvalid wait is legal; the bridge SHALL stall indefinitely with no timeout.

Reset
REQ-038 rst_n low SHALL force IDLE and clear captured registers, rdata_o, rsp_valid_o, misaligned_o, bus_req_o, bus_we_o, bus_be_o and bus_addr_o to 0.
REQ-039 Reset during REQ or WAIT_R SHALL abandon the access; a late bus_rvalid_i after reset SHALL be ignored.

Structure
REQ-040 The state enum and funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) SHALL live in the shared common package/header.
REQ-041 Lane alignment, byte enables and extension SHALL be one combinational sub-module, dmem_lane_align.

Verification
REQ-042 Verify SW 0xDEADBEEF @0x100, gnt in the first REQ cycle -> be=1111, addr=0x100, stall 2 cycles, rsp_valid 1 cycle.
REQ-043 Verify LB @0x103, rdata word 0x80FF_0000, gnt immediate, rvalid 1 cycle later -> rdata_o=0xFFFFFF80, stall 3 cycles.
REQ-044 Verify LHU @0x102, word 0xBEEF_1234 -> rdata_o=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-045 Verify SH 0x0000ABCD @0x102 -> be=1100, wdata=0xABCDABCD; gnt delayed 4 cycles -> stall 6 cycles.
REQ-046 Verify LW @0x101 -> misaligned_o pulse, no bus_req_o, stall_o=0.
REQ-047 Verify reset asserted in WAIT_R, rvalid arriving after deassertion -> no rsp_valid_o, stays IDLE.
